// File: rtl/hazard_scoreboard_if.sv
// Decode/completion bus between the core pipeline and the long-latency hazard scoreboard.
interface hazard_scoreboard_if #(
    parameter int unsigned NREG     = 32,
    parameter int unsigned NRD      = 2,
    parameter int unsigned MAX_PEND = 4
);
    localparam int unsigned AW   = $clog2(NREG);
    localparam int unsigned TAGW = (MAX_PEND > 1) ? $clog2(MAX_PEND) : 1;

    // Decode-side request
    logic [NRD*AW-1:0] rs_d;
    logic [NRD-1:0]    rs_valid_d;
    logic [AW-1:0]     rd_d;
    logic              regwrite_d;
    logic              longop_d;
    logic              advance;
    logic              squash;
    // Long-unit completion
    logic              cmpl_valid;
    logic [TAGW-1:0]   cmpl_tag;
    // Scoreboard responses
    logic [TAGW-1:0]   issue_tag;
    logic              alloc;
    logic [AW-1:0]     cmpl_rd;
    logic              stall_f;
    logic              stall_d;
    logic              flush_e;
    logic [TAGW:0]     pend_cnt;
    logic              err;

    modport slave (
        input  rs_d, rs_valid_d, rd_d, regwrite_d, longop_d, advance, squash,
               cmpl_valid, cmpl_tag,
        output issue_tag, alloc, cmpl_rd, stall_f, stall_d, flush_e, pend_cnt, err
    );

    modport master (
        output rs_d, rs_valid_d, rd_d, regwrite_d, longop_d, advance, squash,
               cmpl_valid, cmpl_tag,
        input  issue_tag, alloc, cmpl_rd, stall_f, stall_d, flush_e, pend_cnt, err
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Scoreboard hazard unit for variable-latency ops (mul/div, wait-state loads).
// Tracks destination registers of outstanding long ops, stalls Decode on
// RAW/WAW/full, and drops speculative entries on branch squash.
// Optional feature macro: SB_CMPL_BYPASS_EN -- a register whose entry completes
// this cycle is treated as not pending (regfile write-through forwards it).
module hazard_scoreboard #(
    parameter int unsigned NREG       = 32,
    parameter int unsigned NRD        = 2,
    parameter int unsigned MAX_PEND   = 4,
    parameter int unsigned SPEC_DEPTH = 2
) (
    input  logic               clk,
    input  logic               reset,
    hazard_scoreboard_if.slave sb
);
    localparam int unsigned AW   = $clog2(NREG);
    localparam int unsigned TAGW = (MAX_PEND > 1) ? $clog2(MAX_PEND) : 1;
    localparam int unsigned AGEW = (SPEC_DEPTH > 0) ? $clog2(SPEC_DEPTH + 1) : 1;
    localparam int unsigned CW   = TAGW + 1;

    logic [MAX_PEND-1:0] r_valid;
    logic [AW-1:0]       r_rd  [MAX_PEND];
    logic [AGEW-1:0]     r_age [MAX_PEND];
    logic [CW-1:0]       r_cnt;
    logic                r_err;

    logic [MAX_PEND-1:0] w_cmpl_mask;
    logic [MAX_PEND-1:0] w_busy;
    logic [MAX_PEND-1:0] w_kill;
    logic [AW-1:0]       w_cmpl_rd;
    logic [TAGW-1:0]     w_free_tag;
    logic                w_free_found;
    logic                w_raw;
    logic                w_waw;
    logic                w_full;
    logic                w_stall;
    logic                w_alloc;
    logic [CW-1:0]       w_nkill;

    // Completion lookup, hazard detection, allocation and free accounting
    always_comb begin
        w_cmpl_mask  = '0;
        w_cmpl_rd    = '0;
        w_busy       = '0;
        w_kill       = '0;
        w_free_tag   = '0;
        w_free_found = 1'b0;
        w_raw        = 1'b0;
        w_waw        = 1'b0;
        w_nkill      = '0;

        for (int i = 0; i < int'(MAX_PEND); i++) begin
            if (sb.cmpl_valid && sb.cmpl_tag == TAGW'(i) && r_valid[i]) begin
                w_cmpl_mask[i] = 1'b1;
                w_cmpl_rd      = r_rd[i];
            end
        end

`ifdef SB_CMPL_BYPASS_EN
        w_busy = r_valid & ~w_cmpl_mask;
`else
        w_busy = r_valid;
`endif

        for (int i = 0; i < int'(MAX_PEND); i++) begin
            if (w_busy[i] && r_rd[i] != '0) begin
                for (int j = 0; j < int'(NRD); j++) begin
                    if (sb.rs_valid_d[j] && sb.rs_d[j*AW +: AW] == r_rd[i]) begin
                        w_raw = 1'b1;
                    end
                end
                if (sb.regwrite_d && sb.rd_d == r_rd[i]) begin
                    w_waw = 1'b1;
                end
            end
        end

        // Lowest free slot of the pre-cycle mask; a slot freed this cycle is still valid here
        for (int i = 0; i < int'(MAX_PEND); i++) begin
            if (!r_valid[i] && !w_free_found) begin
                w_free_tag   = TAGW'(i);
                w_free_found = 1'b1;
            end
        end

        w_full  = (r_cnt == CW'(MAX_PEND));
        w_stall = w_raw | w_waw | (sb.longop_d & w_full);
        w_alloc = sb.longop_d & sb.regwrite_d & (sb.rd_d != '0) & sb.advance &
                  ~w_stall & ~sb.squash & w_free_found;

        // Entries leaving this cycle: completion and/or squash of young entries, counted once
        for (int i = 0; i < int'(MAX_PEND); i++) begin
            w_kill[i] = w_cmpl_mask[i] |
                        (sb.squash & r_valid[i] & (r_age[i] < AGEW'(SPEC_DEPTH)));
            w_nkill   = w_nkill + CW'(w_kill[i]);
        end
    end

    // Entry state, outstanding count and sticky error
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            for (int i = 0; i < int'(MAX_PEND); i++) begin
                r_rd[i]  <= '0;
                r_age[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(MAX_PEND); i++) begin
                if (w_kill[i]) begin
                    r_valid[i] <= 1'b0;
                end
                if (sb.advance && r_valid[i] && r_age[i] < AGEW'(SPEC_DEPTH)) begin
                    r_age[i] <= r_age[i] + AGEW'(1);
                end
                if (w_alloc && w_free_tag == TAGW'(i)) begin
                    r_valid[i] <= 1'b1;
                    r_rd[i]    <= sb.rd_d;
                    r_age[i]   <= '0;
                end
            end
            r_cnt <= r_cnt + CW'(w_alloc) - w_nkill;
            if (sb.cmpl_valid && w_cmpl_mask == '0) begin
                r_err <= 1'b1;
            end
        end
    end

    assign sb.issue_tag = w_free_tag;
    assign sb.alloc     = w_alloc;
    assign sb.cmpl_rd   = w_cmpl_rd;
    assign sb.stall_f   = w_stall;
    assign sb.stall_d   = w_stall;
    assign sb.flush_e   = w_stall;
    assign sb.pend_cnt  = r_cnt;
    assign sb.err       = r_err;

endmodule
